// File: rtl/updown_mod_counter_pkg.sv
// Shared types and constants for the up/down modulus counter.
//
// Contents:
//   DEFAULT_WIDTH - default count width
//   count_t       - count value at the default width
//   count_ext_t   - count value with one extra bit for wrap arithmetic
//   dir_e         - counting direction (DIR_DOWN = 0, DIR_UP = 1)
package counter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;
    typedef logic [DEFAULT_WIDTH:0]   count_ext_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Counter interface between a stimulus/control master and the counter.
//
// Signals:
//   i_en        - count enable
//   i_up_down   - 1 = up, 0 = down
//   i_load      - load request
//   i_load_data - value to load
//   o_count     - registered count
//   o_ovf       - overflow pulse
//   o_udf       - underflow pulse
// Modports: master drives the requests, slave (the counter) drives results.
interface updown_mod_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             i_en;
    logic             i_up_down;
    logic             i_load;
    logic [WIDTH-1:0] i_load_data;
    logic [WIDTH-1:0] o_count;
    logic             o_ovf;
    logic             o_udf;

    modport master (
        output i_en, i_up_down, i_load, i_load_data,
        input  o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_en, i_up_down, i_load, i_load_data,
        output o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/updown_mod_counter_sticky_flag.sv
// Sticky event flag: set by an event, cleared on request; a set in the
// same cycle as a clear wins so no event is ever lost.
//
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   i_set  - event strobe
//   i_clr  - clear request
//   o_flag - latched flag
module sticky_flag
    import counter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_flag <= 1'b0;
        end else if (i_set) begin
            o_flag <= 1'b1;
        end else if (i_clr) begin
            o_flag <= 1'b0;
        end
    end
endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter with programmable modulus (0..i_max) and step.
// Wrapping steps raise a one-cycle o_ovf/o_udf pulse and set sticky flags.
//
// Build option: define COUNTER_SAT_EN for saturating mode (clip at 0/i_max
// and pulse on clip) instead of modular wrap.
//
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   bus (slave)      - i_en, i_up_down, i_load, i_load_data / o_count, o_ovf, o_udf
//   i_max            - modulus limit, legal count range 0..i_max
//   i_step           - step amount, 0 holds
//   i_clr_flags      - clears the sticky flags
//   o_ovf_sticky     - latched overflow
//   o_udf_sticky     - latched underflow
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = 8
)(
    input  logic              i_clk,
    input  logic              i_rst,
    updown_mod_counter_if.slave bus,
    input  logic [WIDTH-1:0]  i_max,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_clr_flags,
    output logic              o_ovf_sticky,
    output logic              o_udf_sticky
);
    localparam logic [WIDTH:0] ONE_E = {{WIDTH{1'b0}}, 1'b1};

    // Returns {ovf, udf, next_count} for one enabled step. Arithmetic is done
    // at WIDTH+1 bits so an all-ones i_max gives a 2^WIDTH modulus.
    function automatic logic [WIDTH+1:0] step_calc(
        input logic [WIDTH-1:0]  cnt,
        input logic [WIDTH-1:0]  max,
        input logic [STEP_W-1:0] stp,
        input dir_e              dir
    );
        logic [WIDTH:0]   cnt_e;
        logic [WIDTH:0]   max_e;
        logic [WIDTH:0]   stp_e;
        logic [WIDTH:0]   sum_e;
        logic [WIDTH-1:0] nxt;
        logic             ovf;
        logic             udf;
        cnt_e = {1'b0, cnt};
        max_e = {1'b0, max};
        stp_e = (WIDTH+1)'(stp);
        sum_e = cnt_e + stp_e;
        nxt   = cnt;
        ovf   = 1'b0;
        udf   = 1'b0;
        if (dir == DIR_UP) begin
            if (cnt_e > max_e) begin
                // Count stranded above a lowered i_max.
`ifdef COUNTER_SAT_EN
                nxt = max;
`else
                nxt = '0;
`endif
                ovf = 1'b1;
            end else if (sum_e > max_e) begin
`ifdef COUNTER_SAT_EN
                nxt = max;
`else
                nxt = WIDTH'(sum_e - (max_e + ONE_E));
`endif
                ovf = 1'b1;
            end else begin
                nxt = sum_e[WIDTH-1:0];
            end
        end else begin
            if (cnt_e > max_e) begin
                nxt = max;
            end else if (cnt_e >= stp_e) begin
                nxt = WIDTH'(cnt_e - stp_e);
            end else begin
`ifdef COUNTER_SAT_EN
                nxt = '0;
`else
                nxt = WIDTH'(cnt_e + (max_e + ONE_E) - stp_e);
`endif
                udf = 1'b1;
            end
        end
        return {ovf, udf, nxt};
    endfunction

    logic [WIDTH-1:0] count_p0;
    logic             ovf_p0;
    logic             udf_p0;
    logic [WIDTH+1:0] step_res;
    logic [WIDTH-1:0] load_val;
    logic             ovf_evt;
    logic             udf_evt;

    always_comb begin
        step_res = step_calc(count_p0, i_max, i_step, dir_e'(bus.i_up_down));
        load_val = (bus.i_load_data > i_max) ? i_max : bus.i_load_data;
        // Load has priority over counting and never pulses.
        ovf_evt  = bus.i_en & ~bus.i_load & step_res[WIDTH+1];
        udf_evt  = bus.i_en & ~bus.i_load & step_res[WIDTH];
    end

    // Stage p0: registered count and event pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_p0 <= '0;
            ovf_p0   <= 1'b0;
            udf_p0   <= 1'b0;
        end else if (bus.i_load) begin
            count_p0 <= load_val;
            ovf_p0   <= 1'b0;
            udf_p0   <= 1'b0;
        end else if (bus.i_en) begin
            count_p0 <= step_res[WIDTH-1:0];
            ovf_p0   <= ovf_evt;
            udf_p0   <= udf_evt;
        end else begin
            ovf_p0   <= 1'b0;
            udf_p0   <= 1'b0;
        end
    end

    assign bus.o_count = count_p0;
    assign bus.o_ovf   = ovf_p0;
    assign bus.o_udf   = udf_p0;

    sticky_flag u_ovf_sticky (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_set  (ovf_evt),
        .i_clr  (i_clr_flags),
        .o_flag (o_ovf_sticky)
    );

    sticky_flag u_udf_sticky (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_set  (udf_evt),
        .i_clr  (i_clr_flags),
        .o_flag (o_udf_sticky)
    );
endmodule
